// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between a requester and the multi-cycle shifter.
// The requester presents an operand, amount and direction with start; the
// shifter answers with busy/done and the working result register.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [CNT_W-1:0] amt;
  logic             dir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             carry;

  modport master (
    output start, din, amt, dir,
    input  busy, done, dout, carry
  );

  modport slave (
    input  start, din, amt, dir,
    output busy, done, dout, carry
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle logical shifter: captures a word with start, then applies one
// single-bit zero-fill shift per clock until the captured amount runs out.
// busy/done are decodes of the registered state, so there is no
// combinational path from start to either handshake output.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_seq_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dout_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;

  // State register; reset can land in any state, including mid-shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: amt of zero skips straight to DONE, the last shift
  // (count of one before the edge) moves to DONE, DONE lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.amt == '0) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on an accepted start, one shift per SHIFT cycle, and
  // hold everything otherwise so the result stays readable after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dout_q  <= bus.din;
            carry_q <= 1'b0;
            cnt     <= bus.amt;
            dir_q   <= bus.dir;
          end
        end
        SHIFT: begin
          if (dir_q) begin
            dout_q  <= {dout_q[WIDTH-2:0], 1'b0};
            carry_q <= dout_q[WIDTH-1];
          end else begin
            dout_q  <= {1'b0, dout_q[WIDTH-1:1]};
            carry_q <= dout_q[0];
          end
          cnt <= cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy  = (state == SHIFT) || (state == DONE);
  assign bus.done  = (state == DONE);
  assign bus.dout  = dout_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: a table of hand-computed vectors plus
// hand-written sequences for intermediate values, ignored starts, result
// hold in IDLE and asynchronous reset in the middle of a shift.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int MAX_CYCLES = 40;

  logic clk;
  logic rst_n;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] amt;
    logic             dir;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_carry;
  } vec_t;

  vec_t vecs [7];

  int tests_run;
  int tests_failed;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one request for a single clock; returns in the negedge right
  // after the accepting edge E0.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a,
                               input logic dr);
    @(negedge clk);
    bus.din   = d;
    bus.amt   = a;
    bus.dir   = dr;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Walk negedges from the cycle after E0 until busy drops, collecting the
  // handshake profile; k counts edges after E0.
  task automatic observe(output int busy_cycles, output int done_cycles,
                         output int done_at, output int timed_out);
    busy_cycles = 0;
    done_cycles = 0;
    done_at     = -1;
    timed_out   = 1;
    for (int k = 0; k < MAX_CYCLES; k++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_cycles++;
        if (done_at < 0) done_at = k;
      end
      if (!bus.busy) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc, da, to;
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{4'b1011, 3'd1, 1'b0, 4'b0101, 1'b1};
    vecs[1] = '{4'b1011, 3'd3, 1'b1, 4'b1000, 1'b1};
    vecs[2] = '{4'b1011, 3'd0, 1'b0, 4'b1011, 1'b0};
    vecs[3] = '{4'b1111, 3'd5, 1'b0, 4'b0000, 1'b0};
    vecs[4] = '{4'b1001, 3'd4, 1'b0, 4'b0000, 1'b1};
    vecs[5] = '{4'b0001, 3'd7, 1'b1, 4'b0000, 1'b0};
    vecs[6] = '{4'b0101, 3'd2, 1'b1, 4'b0100, 1'b1};

    bus.start = 1'b0;
    bus.din   = '0;
    bus.amt   = '0;
    bus.dir   = 1'b0;
    rst_n     = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_dout", int'(bus.dout), 0);
    checkOutput("reset_carry", int'(bus.carry), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].din, vecs[i].amt, vecs[i].dir);
      observe(bc, dc, da, to);
      checkOutput($sformatf("v%0d_timeout", i), to, 0);
      checkOutput($sformatf("v%0d_dout", i), int'(bus.dout), int'(vecs[i].exp_dout));
      checkOutput($sformatf("v%0d_carry", i), int'(bus.carry), int'(vecs[i].exp_carry));
      checkOutput($sformatf("v%0d_busy_cycles", i), bc, int'(vecs[i].amt) + 1);
      checkOutput($sformatf("v%0d_done_cycles", i), dc, 1);
      checkOutput($sformatf("v%0d_done_at", i), da, int'(vecs[i].amt));
    end

    // Result holds in IDLE with start low.
    repeat (2) @(negedge clk);
    checkOutput("hold_dout", int'(bus.dout), 4'b0100);
    checkOutput("hold_carry", int'(bus.carry), 1);
    checkOutput("hold_done", int'(bus.done), 0);

    // Intermediate values of a left shift by three.
    applyStimulus(4'b1011, 3'd3, 1'b1);
    checkOutput("seq_k0_dout", int'(bus.dout), 4'b1011);
    @(negedge clk);
    checkOutput("seq_k1_dout", int'(bus.dout), 4'b0110);
    @(negedge clk);
    checkOutput("seq_k2_dout", int'(bus.dout), 4'b1100);
    checkOutput("seq_k2_done", int'(bus.done), 0);
    @(negedge clk);
    checkOutput("seq_k3_dout", int'(bus.dout), 4'b1000);
    checkOutput("seq_k3_done", int'(bus.done), 1);
    @(negedge clk);
    checkOutput("seq_k4_busy", int'(bus.busy), 0);

    // Start pulses during SHIFT and DONE are ignored.
    applyStimulus(4'b0110, 3'd2, 1'b0);
    bus.start = 1'b1;
    bus.din   = 4'b1111;
    bus.amt   = 3'd7;
    bus.dir   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ign_done", int'(bus.done), 1);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("ign_busy", int'(bus.busy), 0);
    checkOutput("ign_dout", int'(bus.dout), 4'b0001);
    checkOutput("ign_carry", int'(bus.carry), 1);
    bus.dir = 1'b0;

    // Asynchronous reset in the middle of a long shift.
    applyStimulus(4'b1011, 3'd6, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_dout", int'(bus.dout), 0);
    checkOutput("arst_carry", int'(bus.carry), 0);
    checkOutput("arst_busy", int'(bus.busy), 0);
    checkOutput("arst_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1000, 3'd1, 1'b0);
    observe(bc, dc, da, to);
    checkOutput("post_timeout", to, 0);
    checkOutput("post_dout", int'(bus.dout), 4'b0100);
    checkOutput("post_carry", int'(bus.carry), 0);
    checkOutput("post_done_at", da, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
